mem_write_checker: RTL and testbench

//  Synthesizable store-stream checker for the pipelined RISC-V core. Taps MemWriteM/ALUResultM/WriteDataM
//  and compares every committed store against a programmable table of DEPTH expected (address, data) pairs.

---
 rtl/riscv_chk_pkg.sv | 24 ++
 rtl/chk_watchdog.sv | 29 ++
 rtl/mem_write_checker.sv | 197 +++++++++++++++++++
 tb/tb_mem_write_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_chk_pkg.sv
// rtl/riscv_chk_pkg.sv - shared types and constants for the committed-store checker
package riscv_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PASS  = 2'd2,
    ST_FAIL  = 2'd3
  } chk_state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_UNEXP   = 2'd2;
  localparam logic [1:0] FC_DATA    = 2'd3;

  localparam int MODE_ORDERED   = 0;
  localparam int MODE_UNORDERED = 1;

  // Index ports keep at least one bit even for a single-entry table.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/chk_watchdog.sv
// rtl/chk_watchdog.sv - saturating ARMED-cycle counter with timeout flag
module chk_watchdog #(
  parameter int TIMEOUT = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        clr,
  output logic [31:0] count,
  output logic        expired
);

  localparam logic [31:0] LIMIT  = 32'(TIMEOUT - 1);
  localparam logic        ENABLE = (TIMEOUT > 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run && (count != 32'hFFFF_FFFF)) begin
      count <= count + 32'd1;
    end
  end

  // Expiry is a pure function of the count; the caller decides whether it matters.
  assign expired = ENABLE && (count == LIMIT);

endmodule

// File: rtl/mem_write_checker.sv
// rtl/mem_write_checker.sv - compares committed stores against a programmed table of expected (address, data) pairs
module mem_write_checker
  import riscv_chk_pkg::*;
#(
  parameter  int XLEN    = 32,
  parameter  int DEPTH   = 4,
  parameter  int MODE    = 0,
  parameter  int STRICT  = 1,
  parameter  int TIMEOUT = 1000,
  localparam int IW      = idx_width(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            clear,
  input  logic            prog_we,
  input  logic [IW-1:0]   prog_idx,
  input  logic [XLEN-1:0] prog_addr,
  input  logic [XLEN-1:0] prog_data,
  input  logic            MemWriteM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic [1:0]      fail_code,
  output logic [IW-1:0]   fail_idx,
  output logic [CW-1:0]   match_count,
  output logic [31:0]     cycle_count
);

  chk_state_t state;
  chk_state_t state_nxt;

  logic [XLEN-1:0] tab_addr [DEPTH];
  logic [XLEN-1:0] tab_data [DEPTH];
  logic [DEPTH-1:0] hit;

  logic            armed;
  logic            store;
  logic            arm_ev;
  logic            wd_run;
  logic            wd_expired;
  logic [XLEN-1:0] exp_addr;
  logic [XLEN-1:0] exp_data;
  logic            cand_found;
  logic [IW-1:0]   cand_idx;
  logic [XLEN-1:0] cand_data;
  logic            hit_ev;
  logic            data_bad;
  logic            addr_bad;
  logic [IW-1:0]   bad_idx;
  logic            final_hit;

  assign armed  = (state == ST_ARMED);
  assign store  = armed && MemWriteM;
  assign arm_ev = (state == ST_IDLE) && start && !clear;

  // Ordered target entry and unordered candidate (lowest un-hit index with equal address).
  always_comb begin
    exp_addr   = '0;
    exp_data   = '0;
    cand_found = 1'b0;
    cand_idx   = '0;
    cand_data  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) == match_count) begin
        exp_addr = tab_addr[i];
        exp_data = tab_data[i];
      end
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!hit[i] && (tab_addr[i] == ALUResultM)) begin
        cand_found = 1'b1;
        cand_idx   = IW'(i);
        cand_data  = tab_data[i];
      end
    end
  end

  always_comb begin
    hit_ev   = 1'b0;
    data_bad = 1'b0;
    addr_bad = 1'b0;
    bad_idx  = '0;
    if (store) begin
      if (MODE == MODE_ORDERED) begin
        bad_idx = IW'(match_count);
        if (ALUResultM == exp_addr) begin
          if (WriteDataM == exp_data) hit_ev = 1'b1;
          else                        data_bad = 1'b1;
        end else begin
          addr_bad = (STRICT != 0);
        end
      end else begin
        if (cand_found) begin
          if (WriteDataM == cand_data) begin
            hit_ev = 1'b1;
          end else begin
            data_bad = 1'b1;
            bad_idx  = cand_idx;
          end
        end else begin
          addr_bad = (STRICT != 0);
        end
      end
    end
  end

  assign final_hit = hit_ev && (match_count == CW'(DEPTH - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A table-completing store on the expiry edge takes precedence over the timeout.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start) state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (final_hit)                               state_nxt = ST_PASS;
          else if (data_bad || addr_bad || wd_expired) state_nxt = ST_FAIL;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pass = (state == ST_PASS);
    fail = (state == ST_FAIL);
    done = pass || fail;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_count <= '0;
      hit         <= '0;
      fail_code   <= FC_NONE;
      fail_idx    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tab_addr[i] <= '0;
        tab_data[i] <= '0;
      end
    end else begin
      if ((state == ST_IDLE) && prog_we && (int'(prog_idx) < DEPTH)) begin
        tab_addr[prog_idx] <= prog_addr;
        tab_data[prog_idx] <= prog_data;
      end
      if (arm_ev) begin
        match_count <= '0;
        hit         <= '0;
        fail_code   <= FC_NONE;
        fail_idx    <= '0;
      end else if (armed && !clear) begin
        if (hit_ev) begin
          match_count <= match_count + 1'b1;
          if (MODE != MODE_ORDERED) hit <= hit | (DEPTH'(1) << cand_idx);
        end
        if (data_bad) begin
          fail_code <= FC_DATA;
          fail_idx  <= bad_idx;
        end else if (addr_bad) begin
          fail_code <= FC_UNEXP;
          fail_idx  <= bad_idx;
        end else if (wd_expired && !final_hit) begin
          fail_code <= FC_TIMEOUT;
          fail_idx  <= '0;
        end
      end
    end
  end

  // Counting stops on the edge that leaves ARMED, so the reported count is frozen at done.
  assign wd_run = armed && (state_nxt == ST_ARMED);

  logic wd_flag;
  assign wd_expired = armed && wd_flag;

  chk_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .run     (wd_run),
    .clr     (arm_ev),
    .count   (cycle_count),
    .expired (wd_flag)
  );

endmodule

// File: tb/tb_mem_write_checker.sv
// tb/tb_mem_write_checker.sv - table-driven scoreboard bench for ordered and unordered checker instances
module tb_mem_write_checker;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic        prog_we = 1'b0;
  logic        prog_idx = 1'b0;
  logic [31:0] prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        MemWriteM = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;

  logic        done_o, pass_o, fail_o, idx_o;
  logic [1:0]  code_o, mc_o;
  logic [31:0] cyc_o;
  logic        done_u, pass_u, fail_u, idx_u;
  logic [1:0]  code_u, mc_u;
  logic [31:0] cyc_u;

  logic [7:0] act_o, act_u;
  assign act_o = {done_o, pass_o, fail_o, code_o, idx_o, mc_o};
  assign act_u = {done_u, pass_u, fail_u, code_u, idx_u, mc_u};

  always #5 clk = ~clk;

  mem_write_checker #(.XLEN(32), .DEPTH(2), .MODE(0), .STRICT(1), .TIMEOUT(20)) u_ord (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .prog_we(prog_we), .prog_idx(prog_idx), .prog_addr(prog_addr), .prog_data(prog_data),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .done(done_o), .pass(pass_o), .fail(fail_o), .fail_code(code_o), .fail_idx(idx_o),
    .match_count(mc_o), .cycle_count(cyc_o)
  );

  mem_write_checker #(.XLEN(32), .DEPTH(2), .MODE(1), .STRICT(1), .TIMEOUT(20)) u_uno (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .prog_we(prog_we), .prog_idx(prog_idx), .prog_addr(prog_addr), .prog_data(prog_data),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .done(done_u), .pass(pass_u), .fail(fail_u), .fail_code(code_u), .fail_idx(idx_u),
    .match_count(mc_u), .cycle_count(cyc_u)
  );

  typedef struct {
    logic        start, clear, we, idx;
    logic [31:0] pa, pd;
    logic        mw;
    logic [31:0] sa, sd;
    logic [7:0]  eo, eu;
    logic        cc;
    logic [31:0] ecyc;
  } vec_t;

  typedef struct {
    logic [7:0]  eo, eu;
    logic        cc;
    logic [31:0] ecyc;
    int          id;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  function automatic logic [7:0] ex(bit p, bit f, logic [1:0] code, bit idx, logic [1:0] mc);
    return {p | f, p, f, code, idx, mc};
  endfunction

  function automatic vec_t blank(logic [7:0] eo, logic [7:0] eu, bit cc, logic [31:0] ecyc);
    vec_t v;
    v.start = 0; v.clear = 0; v.we = 0; v.idx = 0; v.pa = 0; v.pd = 0;
    v.mw = 0; v.sa = 0; v.sd = 0; v.eo = eo; v.eu = eu; v.cc = cc; v.ecyc = ecyc;
    return v;
  endfunction

  function automatic vec_t P(bit idx, logic [31:0] a, logic [31:0] d, logic [7:0] eo, logic [7:0] eu);
    vec_t v = blank(eo, eu, 0, 0);
    v.we = 1; v.idx = idx; v.pa = a; v.pd = d;
    return v;
  endfunction

  function automatic vec_t C(bit s, bit c, logic [7:0] eo, logic [7:0] eu, bit cc = 0, logic [31:0] ecyc = 0);
    vec_t v = blank(eo, eu, cc, ecyc);
    v.start = s; v.clear = c;
    return v;
  endfunction

  function automatic vec_t S(bit mw, logic [31:0] a, logic [31:0] d, logic [7:0] eo, logic [7:0] eu,
                             bit cc = 0, logic [31:0] ecyc = 0);
    vec_t v = blank(eo, eu, cc, ecyc);
    v.mw = mw; v.sa = a; v.sd = d;
    return v;
  endfunction

  task automatic check8(string name, logic [7:0] act, logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual={done,pass,fail,code,idx,mc}=%b required=%b", name, act, expv);
    end
  endtask

  task automatic check32(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  task automatic step(vec_t v, string tag);
    exp_t e;
    start = v.start; clear = v.clear; prog_we = v.we; prog_idx = v.idx;
    prog_addr = v.pa; prog_data = v.pd;
    MemWriteM = v.mw; ALUResultM = v.sa; WriteDataM = v.sd;
    e.eo = v.eo; e.eu = v.eu; e.cc = v.cc; e.ecyc = v.ecyc; e.id = step_id;
    sb.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard_empty actual=0 required=1", tag);
    end else begin
      e = sb.pop_front();
      check8($sformatf("%s#%0d_ord", tag, e.id), act_o, e.eo);
      check8($sformatf("%s#%0d_uno", tag, e.id), act_u, e.eu);
      if (e.cc) begin
        check32($sformatf("%s#%0d_cyc_ord", tag, e.id), cyc_o, e.ecyc);
        check32($sformatf("%s#%0d_cyc_uno", tag, e.id), cyc_u, e.ecyc);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic [7:0] z;
    z = 8'h00;

    // Shared stimulus; expected outputs for ordered (eo) and unordered (eu) instances.
    tbl.push_back(P(0, 100, 32'h11, z, z));
    tbl.push_back(P(1, 132, 32'hABCDE02E, z, z));
    tbl.push_back(C(1, 0, z, z, 1, 0));
    tbl.push_back(S(1, 100, 32'h11, ex(0,0,0,0,1), ex(0,0,0,0,1)));
    tbl.push_back(S(0, 132, 0, ex(0,0,0,0,1), ex(0,0,0,0,1)));
    tbl.push_back(S(1, 132, 32'hABCDE02E, ex(1,0,0,0,2), ex(1,0,0,0,2), 1, 2));
    v = P(0, 100, 32'h12, ex(1,0,0,0,2), ex(1,0,0,0,2)); v.start = 1;
    tbl.push_back(v);
    tbl.push_back(C(1, 1, ex(0,0,0,0,2), ex(0,0,0,0,2)));
    tbl.push_back(C(1, 0, z, z, 1, 0));
    tbl.push_back(S(1, 132, 32'hABCDE02E, ex(0,1,2,0,0), ex(0,0,0,0,1)));
    tbl.push_back(S(1, 100, 32'h11, ex(0,1,2,0,0), ex(1,0,0,0,2)));
    tbl.push_back(C(0, 1, ex(0,0,2,0,0), ex(0,0,0,0,2)));
    tbl.push_back(C(1, 0, z, z));
    tbl.push_back(S(1, 100, 32'h12, ex(0,1,3,0,0), ex(0,1,3,0,0)));
    tbl.push_back(C(0, 1, ex(0,0,3,0,0), ex(0,0,3,0,0)));
    tbl.push_back(P(0, 96, 7, ex(0,0,3,0,0), ex(0,0,3,0,0)));
    tbl.push_back(P(1, 100, 9, ex(0,0,3,0,0), ex(0,0,3,0,0)));
    tbl.push_back(C(1, 0, z, z));
    tbl.push_back(S(1, 100, 9, ex(0,1,2,0,0), ex(0,0,0,0,1)));
    tbl.push_back(S(1, 100, 9, ex(0,1,2,0,0), ex(0,1,2,0,1)));
    tbl.push_back(C(0, 1, ex(0,0,2,0,0), ex(0,0,2,0,1)));
    tbl.push_back(C(1, 0, z, z));
    tbl.push_back(S(1, 96, 7, ex(0,0,0,0,1), ex(0,0,0,0,1)));
    tbl.push_back(S(0, 555, 9, ex(0,0,0,0,1), ex(0,0,0,0,1)));
    tbl.push_back(S(1, 100, 9, ex(1,0,0,0,2), ex(1,0,0,0,2)));

    repeat (2) @(posedge clk);
    #1;
    check8("reset_ord", act_o, z);
    check8("reset_uno", act_u, z);
    check32("reset_cyc_ord", cyc_o, 0);
    reset = 1'b1;

    foreach (tbl[i]) step(tbl[i], "vec");

    // Watchdog expiry with no stores.
    step(C(0, 1, ex(0,0,0,0,2), ex(0,0,0,0,2)), "to_clr");
    step(C(1, 0, z, z, 1, 0), "to_arm");
    for (int k = 1; k <= 19; k++) step(S(0, 0, 0, z, z, 1, k), "to_wait");
    step(S(0, 0, 0, ex(0,1,1,0,0), ex(0,1,1,0,0), 1, 19), "to_exp");

    // Final match on the expiry edge wins.
    step(C(0, 1, ex(0,0,1,0,0), ex(0,0,1,0,0)), "win_clr");
    step(C(1, 0, z, z, 1, 0), "win_arm");
    step(S(1, 96, 7, ex(0,0,0,0,1), ex(0,0,0,0,1), 1, 1), "win_st0");
    for (int k = 2; k <= 19; k++) step(S(0, 0, 0, ex(0,0,0,0,1), ex(0,0,0,0,1), 1, k), "win_wait");
    step(S(1, 100, 9, ex(1,0,0,0,2), ex(1,0,0,0,2), 1, 19), "win_st1");

    // Asynchronous reset mid-run clears outputs and the table.
    step(C(0, 1, ex(0,0,0,0,2), ex(0,0,0,0,2)), "rr_clr");
    step(C(1, 0, z, z, 1, 0), "rr_arm");
    step(S(1, 96, 7, ex(0,0,0,0,1), ex(0,0,0,0,1), 1, 1), "rr_st");
    #1;
    reset = 1'b0;
    #1;
    check8("midreset_ord", act_o, z);
    check8("midreset_uno", act_u, z);
    check32("midreset_cyc_ord", cyc_o, 0);
    check32("midreset_cyc_uno", cyc_u, 0);
    #1;
    reset = 1'b1;
    step(S(1, 96, 7, z, z), "rr_ignored");
    step(C(1, 0, z, z, 1, 0), "rr_rearm");
    step(S(1, 96, 7, ex(0,1,2,0,0), ex(0,1,2,0,0)), "rr_tblclr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
